sram_ctrl: RTL

SRAM_CTRL -- requirements
Module: sram_ctrl

---
 rtl/sram_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/sram_ctrl.sv
// Single-port asynchronous SRAM controller: one request at a time, with
// configurable read/write strobe lengths and fully registered SRAM pins.
module sram_ctrl #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 32,
  parameter int RD_WAIT = 1,
  parameter int WR_WAIT = 1,
  localparam int BW     = DATA_W / 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              io_req_valid,
  output logic              io_req_ready,
  input  logic              io_req_we,
  input  logic [ADDR_W-1:0] io_req_addr,
  input  logic [DATA_W-1:0] io_req_wdata,
  input  logic [BW-1:0]     io_req_wmask,
  output logic              io_resp_valid,
  output logic [DATA_W-1:0] io_resp_rdata,
  inout  wire  [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [BW-1:0]     ram_be_n,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n,
  output logic [1:0]        state_dbg
);

  // Request handshake: a request transfers on a rising edge where
  // io_req_valid && io_req_ready; ready is only high in IDLE out of reset,
  // and request inputs are don't-care whenever ready is low.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    WHOLD = 2'd3
  } state_t;

  localparam logic [3:0] RD_CNT = 4'(RD_WAIT);
  localparam logic [3:0] WR_CNT = 4'(WR_WAIT);

  state_t            state_q;
  state_t            state_d;
  logic [3:0]        cnt_q;
  logic              accept;
  logic [DATA_W-1:0] wdata_q;
  logic [BW-1:0]     wmask_q;
  logic [BW-1:0]     wmask_d;
  logic              data_oe_q;

  assign io_req_ready = (state_q == IDLE) && reset_n;
  assign accept       = io_req_valid && io_req_ready;
  assign state_dbg    = state_q;
  assign wmask_d      = accept ? io_req_wmask : wmask_q;

  // Data bus is only driven from a flop, and only in WRITE/WHOLD (oe_n high).
  assign ram_data = data_oe_q ? wdata_q : {DATA_W{1'bz}};

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = io_req_we ? WRITE : READ;
      READ:    if (cnt_q == 4'd0) state_d = IDLE;
      WRITE:   if (cnt_q == 4'd0) state_d = WHOLD;
      WHOLD:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q <= 4'd0;
    end else if (accept) begin
      cnt_q <= io_req_we ? WR_CNT : RD_CNT;
    end else if ((state_q == READ || state_q == WRITE) && cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      wdata_q <= io_req_wdata;
      wmask_q <= io_req_wmask;
    end
  end

  // Pin registers are loaded from the next state so each pin changes on the
  // same edge as the state it belongs to.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ram_ce_n      <= 1'b1;
      ram_oe_n      <= 1'b1;
      ram_we_n      <= 1'b1;
      ram_be_n      <= '1;
      ram_addr      <= '0;
      data_oe_q     <= 1'b0;
      io_resp_valid <= 1'b0;
      io_resp_rdata <= '0;
    end else begin
      ram_ce_n  <= (state_d == IDLE);
      ram_oe_n  <= (state_d != READ);
      ram_we_n  <= (state_d != WRITE);
      data_oe_q <= (state_d == WRITE) || (state_d == WHOLD);
      case (state_d)
        IDLE:    ram_be_n <= '1;
        READ:    ram_be_n <= '0;
        default: ram_be_n <= ~wmask_d;
      endcase
      if (accept) begin
        ram_addr <= io_req_addr;
      end
      io_resp_valid <= ((state_q == READ) && (cnt_q == 4'd0)) || (state_q == WHOLD);
      if ((state_q == READ) && (cnt_q == 4'd0)) begin
        io_resp_rdata <= ram_data;
      end
    end
  end

endmodule
